// File: rtl/anc_pkg.sv
// anc_pkg: sample/step/overrun widths and the {e,x,a} tuple shared with anc_top.
package anc_pkg;
  localparam int SAMPLE_W = 16;
  localparam int MU_W = 16;
  localparam int OVR_W = 16;
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] e;
    logic signed [SAMPLE_W-1:0] x;
    logic signed [SAMPLE_W-1:0] a;
  } anc_tuple_t;
endpackage

// File: rtl/anc_sync_fifo.sv
// anc_sync_fifo: register FIFO with a registered show-ahead head and occupancy count.
module anc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int AW = 2,
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [AW:0]  fill
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, rp_n;
  logic [AW:0] fill_n;
  logic [W-1:0] head_n;
  // A push landing on the next read slot must be forwarded, memory is not yet written;
  // once empty the head holds so discarded entries never resurface.
  always_comb begin
    rp_n = rp + AW'(pop);
    fill_n = fill + (AW+1)'(push) - (AW+1)'(pop);
    head_n = (fill_n == '0) ? head : (push && wp == rp_n) ? din : mem[rp_n];
  end
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fill <= '0;
      valid <= 1'b0;
      head <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp_n;
      fill <= fill_n;
      valid <= fill_n != '0;
      head <= head_n;
    end
  end
endmodule

// File: rtl/anc_sample_ingress.sv
// anc_sample_ingress: buffers ADC tuples for anc_top, owns the LMS step size and overrun stats.
module anc_sample_ingress
  import anc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = 2,
  parameter logic [MU_W-1:0] MU_RESET = 16'h0100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_e,
  input  logic [SAMPLE_W-1:0] adc_x,
  input  logic [SAMPLE_W-1:0] adc_a,
  input  logic                mu_wr,
  input  logic [MU_W-1:0]     mu_wdata,
  input  logic                ovr_clr,
  output logic                anc_valid,
  input  logic                anc_ready,
  output logic [SAMPLE_W-1:0] anc_e,
  output logic [SAMPLE_W-1:0] anc_x,
  output logic [SAMPLE_W-1:0] anc_a,
  output logic [MU_W-1:0]     anc_u,
  output logic [AW:0]         fill,
  output logic                ovr_sticky,
  output logic [OVR_W-1:0]    ovr_count
);
  anc_tuple_t din, head;
  logic pop, full, push, drop;
  logic [MU_W-1:0] mu_shadow;
  assign din = '{e: adc_e, x: adc_x, a: adc_a};
  assign pop = anc_valid & anc_ready;
  assign full = fill == (AW+1)'(DEPTH);
  assign push = adc_valid & (~full | pop);
  assign drop = adc_valid & full & ~pop;
  assign anc_e = head.e;
  assign anc_x = head.x;
  assign anc_a = head.a;
  anc_sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W($bits(anc_tuple_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(din),
    .pop(pop),
    .valid(anc_valid),
    .head(head),
    .fill(fill)
  );
  // The step size only changes on a tuple boundary so one sample never sees two mu values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mu_shadow <= MU_RESET;
      anc_u <= MU_RESET;
      ovr_sticky <= 1'b0;
      ovr_count <= '0;
    end else begin
      if (mu_wr) mu_shadow <= mu_wdata;
      if (pop) anc_u <= mu_shadow;
      ovr_sticky <= ovr_clr ? 1'b0 : ovr_sticky | drop;
      ovr_count <= ovr_clr ? '0 : (drop && ovr_count != '1) ? ovr_count + 1'b1 : ovr_count;
    end
  end
endmodule

// File: tb/tb_anc_sample_ingress.sv
// tb_anc_sample_ingress: directed vectors with hand-computed expectations for anc_sample_ingress.
module tb_anc_sample_ingress;
  logic clk = 1'b0;
  logic rst, adc_valid, mu_wr, ovr_clr, anc_ready;
  logic [15:0] adc_e, adc_x, adc_a, mu_wdata;
  logic anc_valid, ovr_sticky;
  logic [15:0] anc_e, anc_x, anc_a, anc_u, ovr_count;
  logic [2:0] fill;
  int checks = 0;
  int failures = 0;
  anc_sample_ingress dut (
    .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_e(adc_e), .adc_x(adc_x), .adc_a(adc_a),
    .mu_wr(mu_wr), .mu_wdata(mu_wdata), .ovr_clr(ovr_clr), .anc_valid(anc_valid),
    .anc_ready(anc_ready), .anc_e(anc_e), .anc_x(anc_x), .anc_a(anc_a), .anc_u(anc_u),
    .fill(fill), .ovr_sticky(ovr_sticky), .ovr_count(ovr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [15:0] e, input logic [15:0] x, input logic [15:0] a);
    adc_e = e;
    adc_x = x;
    adc_a = a;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1; adc_valid = 1'b0; mu_wr = 1'b0; ovr_clr = 1'b0; anc_ready = 1'b0;
    adc_e = '0; adc_x = '0; adc_a = '0; mu_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", anc_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_u", anc_u, 16'h0100);
    chk("rst_sticky", ovr_sticky, 0);
    chk("rst_count", ovr_count, 0);
    chk("rst_e", anc_e, 0);
    anc_ready = 1'b1;
    push(16'h0123, 16'hFFFE, 16'h8000);
    chk("t1_valid", anc_valid, 1);
    chk("t1_fill", fill, 1);
    chk("t1_e", anc_e, 16'h0123);
    chk("t1_x", anc_x, 16'hFFFE);
    chk("t1_a", anc_a, 16'h8000);
    tick();
    chk("t1_valid_drop", anc_valid, 0);
    chk("t1_fill0", fill, 0);
    anc_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(16'(i), 16'(16'hF000 + i), 16'(16'h8000 + i));
    chk("t2_fill4", fill, 4);
    chk("t2_head", anc_e, 1);
    push(16'h0005, 16'hF005, 16'h8005);
    chk("t2_fill_after_drop", fill, 4);
    chk("t2_sticky", ovr_sticky, 1);
    chk("t2_count", ovr_count, 1);
    chk("t2_head_stable", anc_e, 1);
    anc_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain_e", anc_e, i);
      chk("t2_drain_x", anc_x, 16'hF000 + i);
      chk("t2_drain_a", anc_a, 16'h8000 + i);
      tick();
    end
    chk("t2_empty", anc_valid, 0);
    chk("t2_fill0", fill, 0);
    anc_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(16'(16'h0010 + i), 16'h0, 16'h0);
    anc_ready = 1'b1;
    push(16'h0015, 16'h0, 16'h0);
    chk("t3_fill4", fill, 4);
    chk("t3_count", ovr_count, 1);
    for (int i = 2; i <= 5; i++) begin
      chk("t3_order", anc_e, 16'h0010 + i);
      tick();
    end
    chk("t3_empty", anc_valid, 0);
    anc_ready = 1'b0;
    push(16'h0021, 16'h0, 16'h0);
    push(16'h0022, 16'h0, 16'h0);
    mu_wr = 1'b1; mu_wdata = 16'h0040;
    tick();
    mu_wr = 1'b0;
    chk("t4_u_hold1", anc_u, 16'h0100);
    tick();
    chk("t4_u_hold2", anc_u, 16'h0100);
    anc_ready = 1'b1;
    tick();
    anc_ready = 1'b0;
    chk("t4_u_new", anc_u, 16'h0040);
    chk("t4_head", anc_e, 16'h0022);
    mu_wr = 1'b1; mu_wdata = 16'h0080; anc_ready = 1'b1;
    tick();
    mu_wr = 1'b0; anc_ready = 1'b0;
    chk("t4_u_coincident", anc_u, 16'h0040);
    push(16'h0023, 16'h0, 16'h0);
    chk("t4_u_before_pop", anc_u, 16'h0040);
    anc_ready = 1'b1;
    tick();
    anc_ready = 1'b0;
    chk("t4_u_deferred", anc_u, 16'h0080);
    adc_e = 16'h0030; adc_x = 16'h0; adc_a = 16'h0; adc_valid = 1'b1;
    repeat (4) tick();
    chk("t5_fill4", fill, 4);
    repeat (70000) tick();
    chk("t5_sat", ovr_count, 16'hFFFF);
    chk("t5_sticky", ovr_sticky, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("t5_clr_count", ovr_count, 0);
    chk("t5_clr_sticky", ovr_sticky, 0);
    tick();
    adc_valid = 1'b0;
    chk("t5_recount", ovr_count, 1);
    anc_ready = 1'b1;
    repeat (4) tick();
    anc_ready = 1'b0;
    chk("t6_drained", fill, 0);
    push(16'h0AA1, 16'h0, 16'h0);
    push(16'h0AA2, 16'h0, 16'h0);
    push(16'h0AA3, 16'h0, 16'h0);
    chk("t6_fill3", fill, 3);
    chk("t6_valid", anc_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid0", anc_valid, 0);
    chk("t6_fill0", fill, 0);
    chk("t6_u", anc_u, 16'h0100);
    chk("t6_count", ovr_count, 0);
    chk("t6_e0", anc_e, 0);
    tick();
    chk("t6_idle_e", anc_e, 0);
    chk("t6_idle_valid", anc_valid, 0);
    push(16'h0D0D, 16'h0, 16'h0);
    chk("t6_new_e", anc_e, 16'h0D0D);
    chk("t6_new_fill", fill, 1);
    anc_ready = 1'b1;
    tick();
    anc_ready = 1'b0;
    chk("t6_u_shadow_reset", anc_u, 16'h0100);
    chk("t6_final_empty", anc_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
